// File: rtl/rng_sample_scheduler.sv
// rng_sample_scheduler: owns one shared LFSR random-word generator and hands
// its words to NUM_REQ sampling units through a round-robin request/grant
// handshake. The generator is sequenced LOAD -> WARM -> SERVE, and every grant
// is followed by a HOLD window long enough for the generator to shift in a
// completely fresh word before the next grant.
//
// Handshake: req[i] is a level held by requester i until it sees grant[i].
// grant is a one-cycle one-hot pulse, and rnd_valid pulses with it. rnd_out
// carries the word for that grant and holds until the next grant. A requester
// that drops req before being granted is skipped. Each request earns one grant.
//
// Optional build macro RNG_STUCK_CHECK_EN adds the rng_fault output. This
// output flags a generator whose output stops changing, and it blocks grants
// while it is set.
module rng_sample_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int BITLENGTH = 8,
    parameter int WARMUP    = 16,
    parameter int GAP       = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reseed,
    input  logic [BITLENGTH-1:0] seed_in,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [BITLENGTH-1:0] rnd_out,
    output logic                 rnd_valid,
    output logic                 rng_reset,
    output logic [BITLENGTH-1:0] rng_seed,
    input  logic [BITLENGTH-1:0] rng_data,
`ifdef RNG_STUCK_CHECK_EN
    output logic                 rng_fault,
`endif
    output logic                 ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WARM  = 2'd1,
        S_SERVE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 state;
    logic [BITLENGTH-1:0]   seed_reg;
    logic [PW-1:0]          rr_ptr;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          pick;
    logic                   any_req;
    logic                   grant_ok;

    // The generator loads its seed for as long as the FSM sits in LOAD.
    assign rng_reset = (state == S_LOAD);
    assign rng_seed  = seed_reg;
    assign any_req   = |req;
    assign ready     = (state == S_SERVE) && grant_ok;

    // Round-robin pick: lowest set req at or above rr_ptr, else lowest below it.
    // Both passes scan downward so the lowest index wins. The second pass
    // overrides the first, which gives indices at or above rr_ptr priority.
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i[PW-1:0]] && (PW'(i) < rr_ptr)) begin
                pick = PW'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i[PW-1:0]] && (PW'(i) >= rr_ptr)) begin
                pick = PW'(i);
            end
        end
    end

    // Sequencer FSM plus the registered grant, word and pointer updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LOAD;
            seed_reg  <= seed_in;
            rr_ptr    <= '0;
            cnt       <= '0;
            grant     <= '0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
        end else begin
            grant     <= '0;
            rnd_valid <= 1'b0;
            if (reseed) begin
                // Restart the generator; rr_ptr is kept so fairness carries over.
                seed_reg <= seed_in;
                state    <= S_LOAD;
                cnt      <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        state <= S_WARM;
                        cnt   <= CW'(WARMUP - 1);
                    end
                    S_WARM: begin
                        if (cnt == '0) begin
                            state <= S_SERVE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_SERVE: begin
                        if (any_req && grant_ok) begin
                            grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                            rnd_out   <= rng_data;
                            rnd_valid <= 1'b1;
                            rr_ptr    <= (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                            state     <= S_HOLD;
                            cnt       <= CW'(GAP - 1);
                        end
                    end
                    S_HOLD: begin
                        if (cnt == '0) begin
                            state <= S_SERVE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= S_LOAD;
                endcase
            end
        end
    end

`ifdef RNG_STUCK_CHECK_EN
    logic [BITLENGTH-1:0] rng_prev;

    // Sticky stuck detector: the generator output must change on every edge
    // once it has been seeded.
    always_ff @(posedge clk) begin
        if (reset) begin
            rng_prev  <= '0;
            rng_fault <= 1'b0;
        end else begin
            rng_prev <= rng_data;
            if (reseed) begin
                rng_fault <= 1'b0;
            end else if ((state != S_LOAD) && (rng_data == rng_prev)) begin
                rng_fault <= 1'b1;
            end
        end
    end

    assign grant_ok = !rng_fault;
`else
    assign grant_ok = 1'b1;
`endif

endmodule

// File: tb/tb_rng_sample_scheduler.sv
// Bench for rng_sample_scheduler: an 8-bit LFSR generator model drives
// rng_data. A reference model predicts every grant (cycle, one-hot value, word)
// into exp_q, and a negedge monitor pops and compares each observed grant.
// Scenario code also checks latencies, ordering and reseed behaviour directly.
module tb_rng_sample_scheduler;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int WARMUP = 16;
  localparam int GAP    = 7;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         reseed;
  logic [W-1:0] seed_in;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [W-1:0] rnd_out;
  logic         rnd_valid;
  logic         rng_reset;
  logic [W-1:0] rng_seed;
  logic [W-1:0] rng_data;
  logic         ready;
`ifdef RNG_STUCK_CHECK_EN
  logic         rng_fault;
`endif

  always #5 clk = ~clk;

  rng_sample_scheduler #(
    .NUM_REQ(N), .BITLENGTH(W), .WARMUP(WARMUP), .GAP(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reseed(reseed),
    .seed_in(seed_in),
    .req(req),
    .grant(grant),
    .rnd_out(rnd_out),
    .rnd_valid(rnd_valid),
    .rng_reset(rng_reset),
    .rng_seed(rng_seed),
    .rng_data(rng_data),
`ifdef RNG_STUCK_CHECK_EN
    .rng_fault(rng_fault),
`endif
    .ready(ready)
  );

  // ---------------- generator model (one shift per clock) ----------------
  logic [W-1:0] lfsr = '0;
  logic         stuck = 1'b0;
  assign rng_data = stuck ? '0 : lfsr;

  always @(posedge clk) begin
    if (rng_reset) lfsr <= rng_seed;
    else           lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]  cyc;
    logic [N-1:0] g;
    logic [W-1:0] d;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int   cyc = 0;
  int   serve_from = 1 << 30;
  int   m_ptr = 0;
  int   m_pick;
  int   m_idx;
  logic model_off = 1'b0;
  ev_t  m_ev;
  ev_t  mon_ev;

  // Timing model: decisions allowed from WARMUP+2 edges after a restart edge,
  // and GAP+1 edges after each grant.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      serve_from = cyc + WARMUP + 2;
      m_ptr = 0;
    end else if (reseed) begin
      serve_from = cyc + WARMUP + 2;
    end else if (!model_off && cyc >= serve_from && req != '0) begin
      m_pick = -1;
      for (int k = 0; k < N; k++) begin
        m_idx = (m_ptr + k) % N;
        if (m_pick < 0 && req[m_idx]) m_pick = m_idx;
      end
      m_ev.cyc = cyc;
      m_ev.g   = N'(1 << m_pick);
      m_ev.d   = rng_data;
      exp_q.push_back(m_ev);
      m_ptr = (m_pick + 1) % N;
      serve_from = cyc + GAP + 1;
    end
  end

  // Monitor: compare every observed grant against the prediction.
  always @(negedge clk) begin
    if (!reset) begin
      if (grant != '0 || rnd_valid) begin
        check_val("grant_onehot", 32'($countones(grant)), 32'd1);
        check_val("valid_with_grant", 32'(rnd_valid), 32'd1);
        mon_ev = '{cyc: cyc, g: grant, d: rnd_out};
        obs_q.push_back(mon_ev);
        if (exp_q.size() == 0) begin
          check_val("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          m_ev = exp_q.pop_front();
          check_val("grant_cycle", 32'(cyc), m_ev.cyc);
          check_val("grant_value", 32'(grant), 32'(m_ev.g));
          check_val("rnd_out_word", 32'(rnd_out), 32'(m_ev.d));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check_val("missed_grant", 32'(cyc), exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [W-1:0] seed, input logic [N-1:0] r);
    @(negedge clk);
    reset = 1'b1;
    seed_in = seed;
    req = r;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
  endtask

  // Waits (bounded) for the next observed grant; returns at negedge+1.
  task automatic wait_grant(input int max_cyc, output logic [N-1:0] g,
                            output int gc, output logic [W-1:0] gd);
    bit got = 1'b0;
    g = '0; gc = 0; gd = '0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() > 0) begin
        mon_ev = obs_q.pop_front();
        g = mon_ev.g; gc = int'(mon_ev.cyc); gd = mon_ev.d;
        got = 1'b1;
      end
    end
    if (!got) check_val("grant_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] g;
  logic [W-1:0] gd;
  logic [W-1:0] prev_d;
  int           gc, prev_c, rel0, rs, t0;
  logic [N-1:0] seq_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1; reseed = 1'b0; seed_in = 8'h5A; req = 4'b0001;

    // 1: reset state, seed load window and first-grant latency.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rng_reset", 32'(rng_reset), 32'd1);
    check_val("rst_rng_seed", 32'(rng_seed), 32'h5A);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_rnd_valid", 32'(rnd_valid), 32'd0);
    check_val("rst_rnd_out", 32'(rnd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_val("load_after_reset", 32'(rng_reset), 32'd1);
    @(posedge clk);
    #1;
    rel0 = cyc;
    check_val("load_one_cycle", 32'(rng_reset), 32'd0);
    check_val("warm_ready", 32'(ready), 32'd0);
    wait_grant(40, g, gc, gd);
    // First low-reset edge counts as edge 1; the grant lands on edge 18.
    check_val("first_grant_latency", 32'(gc - rel0), 32'd17);
    check_val("first_grant_value", 32'(g), 32'b0001);
    req = '0;

    // 2: all requesting -> round-robin order, exactly GAP+1 apart.
    do_reset(8'h5A, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      wait_grant(40, g, gc, gd);
      check_val("rr_order", 32'(g), 32'(seq_exp[i]));
      if (i > 0) begin
        check_val("rr_spacing", 32'(gc - prev_c), 32'(GAP + 1));
        check_val("word_refreshed", 32'(gd != prev_d), 32'd1);
      end
      prev_c = gc;
      prev_d = gd;
    end

    // 3: partial requests skip idle requesters; dropped req is skipped.
    req = 4'b0101;
    wait_grant(20, g, gc, gd);
    check_val("skip_to_2", 32'(g), 32'b0100);
    wait_grant(20, g, gc, gd);
    check_val("wrap_to_0", 32'(g), 32'b0001);
    wait_grant(20, g, gc, gd);
    check_val("again_2", 32'(g), 32'b0100);
    req = 4'b0001;
    wait_grant(20, g, gc, gd);
    check_val("dropped_req_skipped", 32'(g), 32'b0001);

    // 4: reseed during HOLD; pointer preserved across restart.
    req = 4'b1111;
    repeat (3) @(negedge clk);
    reseed = 1'b1;
    seed_in = 8'h3C;
    @(posedge clk);
    #1;
    rs = cyc;
    check_val("reseed_rng_reset", 32'(rng_reset), 32'd1);
    check_val("reseed_rng_seed", 32'(rng_seed), 32'h3C);
    check_val("reseed_no_grant", 32'(grant), 32'd0);
    @(negedge clk);
    reseed = 1'b0;
    @(posedge clk);
    #1 check_val("reseed_load_one_cycle", 32'(rng_reset), 32'd0);
    wait_grant(60, g, gc, gd);
    check_val("reseed_latency", 32'(gc - rs), 32'(WARMUP + 2));
    check_val("reseed_ptr_kept", 32'(g), 32'b0010);

    // Reseed landing exactly on a SERVE decision edge suppresses that grant.
    repeat (7) @(negedge clk);
    reseed = 1'b1;
    @(posedge clk);
    #1;
    rs = cyc;
    check_val("reseed_on_decision_no_grant", 32'(grant), 32'd0);
    check_val("reseed_on_decision_load", 32'(rng_reset), 32'd1);
    @(negedge clk);
    reseed = 1'b0;
    wait_grant(60, g, gc, gd);
    check_val("reseed2_latency", 32'(gc - rs), 32'(WARMUP + 2));
    check_val("reseed2_ptr_kept", 32'(g), 32'b0100);

    // 5: idle SERVE shows ready; single req granted one cycle later.
    req = '0;
    repeat (12) @(negedge clk);
    #1;
    check_val("idle_ready", 32'(ready), 32'd1);
    check_val("idle_no_grant", 32'(grant), 32'd0);
    req = 4'b1000;
    t0 = cyc;
    wait_grant(5, g, gc, gd);
    check_val("serve_latency", 32'(gc - t0), 32'd1);
    check_val("single_req", 32'(g), 32'b1000);
    req = '0;

`ifdef RNG_STUCK_CHECK_EN
    // 6: stuck generator raises a sticky fault and blocks grants until reseed.
    repeat (12) @(negedge clk);
    model_off = 1'b1;
    stuck = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("fault_set", 32'(rng_fault), 32'd1);
    check_val("fault_not_ready", 32'(ready), 32'd0);
    @(negedge clk);
    req = 4'b1111;
    repeat (20) @(negedge clk);
    #1 check_val("fault_sticky", 32'(rng_fault), 32'd1);
    @(negedge clk);
    stuck = 1'b0;
    reseed = 1'b1;
    model_off = 1'b0;
    @(posedge clk);
    #1 check_val("fault_cleared", 32'(rng_fault), 32'd0);
    @(negedge clk);
    reseed = 1'b0;
    wait_grant(60, g, gc, gd);
    check_val("post_fault_grant", 32'(g), 32'b0001);
    req = '0;
`endif

    repeat (10) @(negedge clk);
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
